// File: rtl/fetch_decode.sv
// Fetch/decode stage of the single-cycle LEGv8 CPU: PC register, 1K-word
// instruction ROM, instruction decode and next-PC selection.
module fetch_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        negative,
  input  logic        zero,
  input  logic        BrTaken,
  input  logic [63:0] Db,
  output logic [63:0] pc,
  output logic [63:0] BLT,
  output logic [18:0] COND_BR_addr,
  output logic [25:0] BR_addr,
  output logic        Reg2Loc,
  output logic        ALUsrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        BLsignal,
  output logic        update,
  output logic        cbz,
  output logic        branch,
  output logic        cond,
  output logic [2:0]  ALUop,
  output logic [4:0]  Rn,
  output logic [4:0]  Rd,
  output logic [4:0]  Rm,
  output logic [4:0]  Rt,
  output logic [11:0] ALU_imm,
  output logic [8:0]  DT_addr,
  output logic [5:0]  shamt
);

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_LSR   = 3'b111;

  logic [31:0]        r_imem [0:1023];
  logic [63:0]        r_pc;
  logic [31:0]        w_instr;
  logic               w_brsignal;
  logic               w_uncondbr;
  logic signed [63:0] w_br_off;
  logic [63:0]        w_br_target;
  logic [63:0]        w_pc_plus4;

  assign w_instr      = r_imem[r_pc[11:2]];
  assign w_pc_plus4   = r_pc + 64'd4;
  assign pc           = r_pc;
  assign BLT          = w_pc_plus4;
  assign COND_BR_addr = w_instr[23:5];
  assign BR_addr      = w_instr[25:0];
  assign Rn           = w_instr[9:5];
  assign Rd           = w_instr[4:0];
  assign Rm           = w_instr[20:16];
  assign Rt           = w_brsignal ? w_instr[9:5] : w_instr[4:0];
  assign ALU_imm      = w_instr[21:10];
  assign DT_addr      = w_instr[20:12];
  assign shamt        = w_instr[15:10];

  always_comb begin
    Reg2Loc    = 1'b0;
    ALUsrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    BLsignal   = 1'b0;
    update     = 1'b0;
    cbz        = 1'b0;
    branch     = 1'b0;
    cond       = 1'b0;
    ALUop      = ALU_PASSB;
    w_brsignal = 1'b0;
    w_uncondbr = 1'b0;
    casez (w_instr[31:21])
      11'b1001000100?: begin
        ALUsrc = 1'b1; RegWrite = 1'b1; ALUop = ALU_ADD;
      end
      11'b10101011000: begin
        Reg2Loc = 1'b1; RegWrite = 1'b1; update = 1'b1; ALUop = ALU_ADD;
      end
      11'b11101011000: begin
        Reg2Loc = 1'b1; RegWrite = 1'b1; update = 1'b1; ALUop = ALU_SUB;
      end
      11'b10001010000: begin
        Reg2Loc = 1'b1; RegWrite = 1'b1; ALUop = ALU_AND;
      end
      11'b11001010000: begin
        Reg2Loc = 1'b1; RegWrite = 1'b1; ALUop = ALU_XOR;
      end
      11'b11010011010: begin
        RegWrite = 1'b1; ALUop = ALU_LSR;
      end
      11'b11111000010: begin
        ALUsrc = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; ALUop = ALU_ADD;
      end
      11'b11111000000: begin
        ALUsrc = 1'b1; MemWrite = 1'b1; ALUop = ALU_ADD;
      end
      11'b000101?????: begin
        branch = 1'b1; w_uncondbr = 1'b1;
      end
      11'b100101?????: begin
        branch = 1'b1; BLsignal = 1'b1; RegWrite = 1'b1; w_uncondbr = 1'b1;
      end
      // Only EQ and LT are implemented; other condition codes never fire.
      11'b01010100???: begin
        cond = ((w_instr[4:0] == 5'h00) && zero) ||
               ((w_instr[4:0] == 5'h0B) && negative);
      end
      11'b10110100???: begin
        cbz = 1'b1; ALUop = ALU_PASSB;
      end
      11'b11010110000: begin
        w_brsignal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (w_uncondbr)
      w_br_off = {{38{w_instr[25]}}, w_instr[25:0]};
    else
      w_br_off = {{45{w_instr[23]}}, w_instr[23:5]};
  end

  assign w_br_target = r_pc + $unsigned(w_br_off <<< 2);

  // A decoded BR outranks the externally computed BrTaken.
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= 64'd0;
    else if (w_brsignal)
      r_pc <= Db;
    else if (BrTaken)
      r_pc <= w_br_target;
    else
      r_pc <= w_pc_plus4;
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: preloads the instruction ROM, then walks
// the PC through decode, branch, BR, wrap and reset scenarios.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset, negative, zero, BrTaken;
  logic [63:0] Db;
  logic [63:0] pc, BLT;
  logic [18:0] COND_BR_addr;
  logic [25:0] BR_addr;
  logic        Reg2Loc, ALUsrc, MemtoReg, RegWrite, MemWrite, BLsignal, update;
  logic        cbz, branch, cond;
  logic [2:0]  ALUop;
  logic [4:0]  Rn, Rd, Rm, Rt;
  logic [11:0] ALU_imm;
  logic [8:0]  DT_addr;
  logic [5:0]  shamt;
  logic [12:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  fetch_decode dut (
    .clk(clk), .reset(reset), .negative(negative), .zero(zero),
    .BrTaken(BrTaken), .Db(Db), .pc(pc), .BLT(BLT),
    .COND_BR_addr(COND_BR_addr), .BR_addr(BR_addr),
    .Reg2Loc(Reg2Loc), .ALUsrc(ALUsrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .BLsignal(BLsignal),
    .update(update), .cbz(cbz), .branch(branch), .cond(cond),
    .ALUop(ALUop), .Rn(Rn), .Rd(Rd), .Rm(Rm), .Rt(Rt),
    .ALU_imm(ALU_imm), .DT_addr(DT_addr), .shamt(shamt)
  );

  always #5 clk = ~clk;

  // {Reg2Loc,ALUsrc,MemtoReg,RegWrite,MemWrite,BLsignal,update,cbz,branch,cond,ALUop}
  assign ctl = {Reg2Loc, ALUsrc, MemtoReg, RegWrite, MemWrite, BLsignal,
                update, cbz, branch, cond, ALUop};

  localparam logic [12:0] C_ADDI = 13'b0101000000_010;
  localparam logic [12:0] C_ADDS = 13'b1001001000_010;
  localparam logic [12:0] C_SUBS = 13'b1001001000_011;
  localparam logic [12:0] C_AND  = 13'b1001000000_100;
  localparam logic [12:0] C_EOR  = 13'b1001000000_110;
  localparam logic [12:0] C_LSR  = 13'b0001000000_111;
  localparam logic [12:0] C_LDUR = 13'b0111000000_010;
  localparam logic [12:0] C_STUR = 13'b0100100000_010;
  localparam logic [12:0] C_B    = 13'b0000000010_000;
  localparam logic [12:0] C_BL   = 13'b0001010010_000;
  localparam logic [12:0] C_CBZ  = 13'b0000000100_000;
  localparam logic [12:0] C_COND = 13'b0000000001_000;
  localparam logic [12:0] C_NONE = 13'b0000000000_000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then reach address a by walking sequentially (a <= 0x28, aligned)
  // or by walking to the BR at 0x28 with Db = a.
  task automatic goto(input logic [63:0] a);
    reset = 1'b1; BrTaken = 1'b0; Db = 64'd0; negative = 1'b0; zero = 1'b0;
    tick();
    reset = 1'b0;
    if (a <= 64'h28 && a[1:0] == 2'b00) begin
      for (int i = 0; i < int'(a[7:2]); i++) tick();
    end else begin
      for (int i = 0; i < 10; i++) tick();
      Db = a;
      tick();
    end
    n_checks++;
    if (pc !== a) begin
      n_errors++;
      $display("FAIL goto: pc=%h want %h", pc, a);
    end
  endtask

  task automatic test_reset();
    goto(64'h28);
    Db = 64'h40; BrTaken = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; BrTaken = 1'b0;
    n_checks++;
    if (pc !== 64'd0) begin n_errors++; $display("FAIL reset_pc: pc=%h want 0", pc); end
    n_checks++;
    if (BLT !== 64'd4) begin n_errors++; $display("FAIL reset_blt: BLT=%h want 4", BLT); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 64'(4 * i)) begin
        n_errors++;
        $display("FAIL seq_pc: pc=%h want %h", pc, 64'(4 * i));
      end
    end
  endtask

  task automatic test_addi();
    goto(64'h0);
    n_checks++;
    if (ALU_imm !== 12'd126 || Rn !== 5'd11 || Rd !== 5'd15) begin
      n_errors++;
      $display("FAIL addi_fields: imm=%0d Rn=%0d Rd=%0d want 126 11 15", ALU_imm, Rn, Rd);
    end
    n_checks++;
    if (ctl !== C_ADDI) begin n_errors++; $display("FAIL addi_ctl: ctl=%b want %b", ctl, C_ADDI); end
  endtask

  task automatic test_decode_walk();
    logic [12:0] exp_ctl [10];
    exp_ctl = '{C_ADDI, C_ADDS, C_B, C_SUBS, C_BL, C_AND, C_EOR, C_LSR, C_LDUR, C_STUR};
    goto(64'h0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (ctl !== exp_ctl[i]) begin
        n_errors++;
        $display("FAIL walk_ctl: pc=%h ctl=%b want %b", pc, ctl, exp_ctl[i]);
      end
      if (pc == 64'h04) begin
        n_checks++;
        if (Rm !== 5'd3 || Rn !== 5'd2 || Rd !== 5'd1) begin
          n_errors++;
          $display("FAIL adds_regs: Rm=%0d Rn=%0d Rd=%0d want 3 2 1", Rm, Rn, Rd);
        end
      end
      if (pc == 64'h1C) begin
        n_checks++;
        if (shamt !== 6'd4) begin n_errors++; $display("FAIL lsr_shamt: %0d want 4", shamt); end
      end
      if (pc == 64'h20) begin
        n_checks++;
        if (DT_addr !== 9'd8 || Rt !== 5'd1) begin
          n_errors++;
          $display("FAIL ldur_fields: DT=%0d Rt=%0d want 8 1", DT_addr, Rt);
        end
      end
      tick();
    end
  endtask

  task automatic test_uncond_branch();
    goto(64'h8);
    n_checks++;
    if (BR_addr !== 26'd3) begin n_errors++; $display("FAIL b_addr: %h want 3", BR_addr); end
    BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'd20) begin n_errors++; $display("FAIL b_fwd: pc=%h want 14", pc); end
    goto(64'h44);
    n_checks++;
    if (BR_addr !== 26'h3FFFFFF) begin n_errors++; $display("FAIL bneg_addr: %h", BR_addr); end
    BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'h40) begin n_errors++; $display("FAIL b_back: pc=%h want 40", pc); end
  endtask

  task automatic test_bl();
    goto(64'h10);
    n_checks++;
    if (BLT !== 64'h14) begin n_errors++; $display("FAIL bl_blt: %h want 14", BLT); end
    n_checks++;
    if (ctl !== C_BL) begin n_errors++; $display("FAIL bl_ctl: %b want %b", ctl, C_BL); end
    BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'h20) begin n_errors++; $display("FAIL bl_target: pc=%h want 20", pc); end
  endtask

  task automatic test_bcond();
    goto(64'h2C);
    n_checks++;
    if (COND_BR_addr !== 19'd2) begin n_errors++; $display("FAIL blt_off: %h want 2", COND_BR_addr); end
    negative = 1'b1; #1;
    n_checks++;
    if (ctl !== C_COND) begin n_errors++; $display("FAIL blt_n1: ctl=%b want %b", ctl, C_COND); end
    negative = 1'b0; zero = 1'b1; #1;
    n_checks++;
    if (cond !== 1'b0) begin n_errors++; $display("FAIL blt_n0: cond=%b want 0", cond); end
    zero = 1'b0; BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'h34 || ctl !== C_CBZ || Rt !== 5'd3) begin
      n_errors++;
      $display("FAIL cbz_dec: pc=%h ctl=%b Rt=%0d want 34 %b 3", pc, ctl, Rt, C_CBZ);
    end
    tick();
    n_checks++;
    if (pc !== 64'h30) begin n_errors++; $display("FAIL cbz_back: pc=%h want 30", pc); end
    BrTaken = 1'b0; zero = 1'b1; #1;
    n_checks++;
    if (cond !== 1'b1) begin n_errors++; $display("FAIL beq_z1: cond=%b want 1", cond); end
    zero = 1'b0; negative = 1'b1; #1;
    n_checks++;
    if (cond !== 1'b0) begin n_errors++; $display("FAIL beq_z0: cond=%b want 0", cond); end
    tick();
    tick();
    zero = 1'b1; #1;
    n_checks++;
    if (pc !== 64'h38 || cond !== 1'b0) begin
      n_errors++;
      $display("FAIL bne_cond: pc=%h cond=%b want 38 0", pc, cond);
    end
  endtask

  task automatic test_br();
    goto(64'h28);
    n_checks++;
    if (Rt !== 5'd5 || Reg2Loc !== 1'b0 || ctl !== C_NONE) begin
      n_errors++;
      $display("FAIL br_dec: Rt=%0d Reg2Loc=%b ctl=%b want 5 0 0", Rt, Reg2Loc, ctl);
    end
    Db = 64'h40; BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'h40) begin n_errors++; $display("FAIL br_target: pc=%h want 40", pc); end
  endtask

  task automatic test_unknown();
    goto(64'h40);
    n_checks++;
    if (ctl !== C_NONE) begin n_errors++; $display("FAIL nop_ctl: %b want 0", ctl); end
    tick();
    n_checks++;
    if (pc !== 64'h44) begin n_errors++; $display("FAIL nop_next: pc=%h want 44", pc); end
  endtask

  task automatic test_wrap();
    goto(64'hFFFF_FFFF_FFFF_FFFC);
    n_checks++;
    if (BLT !== 64'd0 || ctl !== C_NONE) begin
      n_errors++;
      $display("FAIL wrap_dec: BLT=%h ctl=%b want 0 0", BLT, ctl);
    end
    tick();
    n_checks++;
    if (pc !== 64'd0) begin n_errors++; $display("FAIL wrap_pc: pc=%h want 0", pc); end
  endtask

  task automatic test_misaligned();
    goto(64'h0A);
    n_checks++;
    if (BR_addr !== 26'd3 || ctl !== C_B || BLT !== 64'h0E) begin
      n_errors++;
      $display("FAIL misalign_dec: BR_addr=%h ctl=%b BLT=%h want 3 %b e", BR_addr, ctl, C_B, BLT);
    end
    BrTaken = 1'b1;
    tick();
    n_checks++;
    if (pc !== 64'h16) begin n_errors++; $display("FAIL misalign_br: pc=%h want 16", pc); end
  endtask

  initial begin
    reset = 1'b1; negative = 1'b0; zero = 1'b0; BrTaken = 1'b0; Db = 64'd0;
    for (int i = 0; i < 1024; i++) dut.r_imem[i] = 32'h0;
    dut.r_imem[0]  = 32'h9101F96F; // ADDI X15, X11, #126
    dut.r_imem[1]  = 32'hAB030041; // ADDS X1, X2, X3
    dut.r_imem[2]  = 32'h14000003; // B +3
    dut.r_imem[3]  = 32'hEB030041; // SUBS
    dut.r_imem[4]  = 32'h94000004; // BL +4
    dut.r_imem[5]  = 32'h8A030041; // AND
    dut.r_imem[6]  = 32'hCA030041; // EOR
    dut.r_imem[7]  = 32'hD3401041; // LSR #4
    dut.r_imem[8]  = 32'hF8408041; // LDUR X1, [X2,#8]
    dut.r_imem[9]  = 32'hF8008041; // STUR
    dut.r_imem[10] = 32'hD61F00A0; // BR X5
    dut.r_imem[11] = 32'h5400004B; // B.LT +2
    dut.r_imem[12] = 32'h54000040; // B.EQ +2
    dut.r_imem[13] = 32'hB4FFFFE3; // CBZ X3, -1
    dut.r_imem[14] = 32'h54000041; // B.NE
    dut.r_imem[17] = 32'h17FFFFFF; // B -1
    test_reset();
    test_addi();
    test_decode_walk();
    test_uncond_branch();
    test_bl();
    test_bcond();
    test_br();
    test_unknown();
    test_wrap();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
